mips_cpu_muldiv_unit: RTL

//  Multi-cycle integer multiply/divide unit owning the HI/LO register pair; companion to the

---
 rtl/mips_cpu_muldiv_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mips_cpu_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one product/quotient bit per clock.
// Signed ops run on magnitudes and are sign-corrected in a single FIX cycle.
module mips_cpu_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   p;        // {acc/remainder, multiplier/quotient}
  logic [WIDTH-1:0]     opnd;     // multiplicand or divisor magnitude
  logic                 neg_lo;   // product sign (MUL) or quotient sign (DIV)
  logic                 neg_hi;   // remainder sign: follows the dividend
  logic                 dz;
  logic                 is_div;

  // Operand magnitudes for issue
  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign signed_op = (op == F_MULT) || (op == F_DIV);
  assign a_neg     = signed_op & rs_content[WIDTH-1];
  assign b_neg     = signed_op & rt_content[WIDTH-1];
  assign a_mag     = a_neg ? -rs_content : rs_content;
  assign b_mag     = b_neg ? -rt_content : rt_content;

  // Shift-add step: add multiplicand into the upper half, then shift right with carry
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, p[WIDTH-1:1]};

  // Restoring-divide step: remainder < divisor, so the shifted value fits WIDTH+1 bits
  logic [WIDTH:0]     rem_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opnd};
  assign div_ge   = rem_sh >= {1'b0, opnd};
  assign div_next = div_ge ? {div_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0],   p[WIDTH-2:0], 1'b0};

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_lo ? -p : p;
  assign quo_fix  = dz ? '1 : (neg_lo ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
  assign rem_fix  = neg_hi ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];

  logic cnt_last;
  assign cnt_last = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      p        <= '0;
      opnd     <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      dz       <= 1'b0;
      is_div   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            case (op)
              F_MULT, F_MULTU: begin
                p      <= {{WIDTH{1'b0}}, b_mag};
                opnd   <= a_mag;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= 1'b0;
                dz     <= 1'b0;
                is_div <= 1'b0;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= S_MUL;
              end
              F_DIV, F_DIVU: begin
                p      <= {{WIDTH{1'b0}}, a_mag};
                opnd   <= b_mag;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg;
                dz     <= (rt_content == '0);
                is_div <= 1'b1;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= S_DIV;
              end
              F_MTHI: begin
                hi   <= rs_content;
                done <= 1'b1;
              end
              F_MTLO: begin
                lo   <= rs_content;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            p   <= (state == S_MUL) ? mul_next : div_next;
            cnt <= cnt + 1'b1;
            if (cnt_last) state <= S_FIX;
          end
        end
        S_FIX: begin
          busy  <= 1'b0;
          state <= S_IDLE;
          if (!flush) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            done     <= 1'b1;
            div_zero <= dz;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
